// File: rtl/cross_bar_pkg.sv
// Shared constants, types and helpers for the N x M req/ack/resp crossbar.
package cross_bar_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Wide all-ones pattern; users truncate to their data width.
  localparam int unsigned             DECERR_MAX_W = 1024;
  localparam logic [DECERR_MAX_W-1:0] DECERR_DATA  = '1;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANTED
  } arb_state_e;

  // Select/index width: at least one bit even for a single port.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter
  import cross_bar_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  // Scan offsets from ptr upward, wrapping modulo N, and keep the first hit
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (en && !valid && req[j] && (((32'(ptr) + i) % N) == j)) begin
          valid  = 1'b1;
          gnt[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cross_bar_nxm.sv
// N-master x M-slave crossbar: per-slave round-robin arbitration, in-order
// read-response routing FIFOs and an internal decode-error responder.
module cross_bar_nxm
  import cross_bar_pkg::*;
#(
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned N_SLAVES  = 2
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [N_MASTERS-1:0]          s_req,
  input  logic [N_MASTERS*AWIDTH-1:0]   s_addr,
  input  logic [N_MASTERS-1:0]          s_cmd,
  input  logic [N_MASTERS*DWIDTH-1:0]   s_wdata,
  output logic [N_MASTERS-1:0]          s_ack,
  output logic [N_MASTERS*DWIDTH-1:0]   s_rdata,
  output logic [N_MASTERS-1:0]          s_resp,
  output logic [N_SLAVES-1:0]           m_req,
  output logic [N_SLAVES*AWIDTH-1:0]    m_addr,
  output logic [N_SLAVES-1:0]           m_cmd,
  output logic [N_SLAVES*DWIDTH-1:0]    m_wdata,
  input  logic [N_SLAVES-1:0]           m_ack,
  input  logic [N_SLAVES*DWIDTH-1:0]    m_rdata,
  input  logic [N_SLAVES-1:0]           m_resp
);

  localparam int unsigned SW  = sel_width(N_SLAVES);
  localparam int unsigned IW  = sel_width(N_MASTERS);
  localparam int unsigned CW  = $clog2(N_MASTERS + 1);
  localparam int unsigned NT  = N_SLAVES + 1;   // slaves plus error responder
  localparam int unsigned ERR = N_SLAVES;

  logic [NT-1:0][N_MASTERS-1:0] tgt_req;
  logic [NT-1:0]                ack_in;
  logic [NT-1:0]                resp_in;
  logic [NT-1:0]                acked;
  logic [NT-1:0]                pop;
  logic [NT-1:0]                push_rd;
  logic [DWIDTH-1:0]            rdata_in [NT];
  logic [IW-1:0]                owner_q  [NT];
  logic [IW-1:0]                head_q   [NT];
  logic [N_MASTERS-1:0]         rd_busy;
  logic [N_MASTERS-1:0]         rd_set;
  logic [N_MASTERS-1:0]         rd_clr;

  // Address decode and eligibility per master
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_dec
    logic [SW-1:0] idx;
    logic          ok;
    assign idx = s_addr[i*AWIDTH + AWIDTH - 1 -: SW];
    assign ok  = s_req[i] && ((s_cmd[i] == CMD_WRITE) || !rd_busy[i]);
    for (genvar j = 0; j < NT; j++) begin : g_hit
      if (j < N_SLAVES) begin : g_s
        assign tgt_req[j][i] = ok && (32'(idx) == 32'(j));
      end else begin : g_e
        assign tgt_req[j][i] = ok && (32'(idx) >= 32'(N_SLAVES));
      end
    end
  end

  // Per-target arbiter, grant state and response-routing FIFO
  for (genvar j = 0; j < NT; j++) begin : g_tgt
    arb_state_e           state;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        gnt_idx;
    logic                 cmd_q;
    logic [N_MASTERS-1:0] gnt;
    logic                 gvalid;
    logic                 take;
    logic [IW-1:0]        fifo_mem [N_MASTERS];
    logic [IW-1:0]        wp;
    logic [IW-1:0]        rp;
    logic [CW-1:0]        cnt;
    logic                 push;
    logic                 popv;

    rr_arbiter #(.N(N_MASTERS)) u_arb (
      .req   (tgt_req[j]),
      .ptr   (ptr),
      .en    (state == ARB_IDLE),
      .gnt   (gnt),
      .valid (gvalid)
    );

    // One-hot grant to master index
    always_comb begin
      gnt_idx = '0;
      for (int unsigned k = 0; k < N_MASTERS; k++) begin
        if (gnt[k]) gnt_idx = IW'(k);
      end
    end

    assign take       = (state == ARB_IDLE) && gvalid;
    assign acked[j]   = (state == ARB_GRANTED) && ack_in[j];
    assign push       = acked[j] && (cmd_q == CMD_READ);
    assign popv       = resp_in[j] && (cnt != '0);
    assign owner_q[j] = owner;
    assign head_q[j]  = fifo_mem[rp];
    assign pop[j]     = popv;
    assign push_rd[j] = push;

    // IDLE/GRANTED state, owner capture and round-robin pointer advance
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        state <= ARB_IDLE;
        owner <= '0;
        ptr   <= '0;
        cmd_q <= 1'b0;
      end else if (take) begin
        state <= ARB_GRANTED;
        owner <= gnt_idx;
        cmd_q <= s_cmd[gnt_idx];
      end else if (acked[j]) begin
        state <= ARB_IDLE;
        ptr   <= (owner == IW'(N_MASTERS - 1)) ? '0 : owner + IW'(1);
      end
    end

    // Circular buffer of read-owner IDs, popped in response order
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        for (int unsigned k = 0; k < N_MASTERS; k++) fifo_mem[k] <= '0;
      end else begin
        if (push) begin
          fifo_mem[wp] <= owner;
          wp <= (wp == IW'(N_MASTERS - 1)) ? '0 : wp + IW'(1);
        end
        if (popv) begin
          rp <= (rp == IW'(N_MASTERS - 1)) ? '0 : rp + IW'(1);
        end
        if (push && !popv) begin
          cnt <= cnt + CW'(1);
        end else if (!push && popv) begin
          cnt <= cnt - CW'(1);
        end
      end
    end

    if (j < N_SLAVES) begin : g_slv
      logic [AWIDTH-1:0] addr_q;
      logic [DWIDTH-1:0] wdata_q;

      // Capture the granted master's address and write data
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          addr_q  <= '0;
          wdata_q <= '0;
        end else if (take) begin
          addr_q  <= s_addr[32'(gnt_idx)*AWIDTH +: AWIDTH];
          wdata_q <= s_wdata[32'(gnt_idx)*DWIDTH +: DWIDTH];
        end
      end

      assign m_req[j]                     = (state == ARB_GRANTED);
      assign m_cmd[j]                     = cmd_q;
      assign m_addr[j*AWIDTH +: AWIDTH]   = addr_q;
      assign m_wdata[j*DWIDTH +: DWIDTH]  = wdata_q;
      assign ack_in[j]                    = m_ack[j];
      assign resp_in[j]                   = m_resp[j];
      assign rdata_in[j]                  = m_rdata[j*DWIDTH +: DWIDTH];
    end else begin : g_err
      logic err_ack_q;
      logic err_resp_q;

      // Ack one cycle into the grant; answer reads one cycle after the ack
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          err_ack_q  <= 1'b0;
          err_resp_q <= 1'b0;
        end else begin
          err_ack_q  <= (state == ARB_GRANTED) && !err_ack_q;
          err_resp_q <= push;
        end
      end

      assign ack_in[j]   = err_ack_q;
      assign resp_in[j]  = err_resp_q;
      assign rdata_in[j] = DWIDTH'(DECERR_DATA);
    end
  end

  // Route acks and read responses back to their masters
  always_comb begin
    s_ack   = '0;
    s_resp  = '0;
    s_rdata = '0;
    rd_set  = '0;
    rd_clr  = '0;
    for (int unsigned j = 0; j < NT; j++) begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        if (acked[j] && (owner_q[j] == IW'(i))) s_ack[i] = 1'b1;
        if (push_rd[j] && (owner_q[j] == IW'(i))) rd_set[i] = 1'b1;
        if (pop[j] && (head_q[j] == IW'(i))) begin
          s_resp[i] = 1'b1;
          rd_clr[i] = 1'b1;
          s_rdata[i*DWIDTH +: DWIDTH] = s_rdata[i*DWIDTH +: DWIDTH] | rdata_in[j];
        end
      end
    end
  end

  // One outstanding read per master
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_busy <= '0;
    end else begin
      rd_busy <= (rd_busy | rd_set) & ~rd_clr;
    end
  end

  // Error target index kept for readability of the decode above
  if (ERR != N_SLAVES) begin : g_never
    $error("error responder index mismatch");
  end

endmodule
